// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bus between the VGA timing generator and its colour source / pin consumer.
// The generator side (master) drives counters, strobes and the registered pin byte,
// and receives the colour for the current pixel.
interface vga_timing_gen_if;
  logic [5:0] rgb_in;
  logic       pix_ce;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       active;
  logic       line_start;
  logic       frame_start;
  logic [7:0] uo_out;

  modport master (
    input  rgb_in,
    output pix_ce, pix_x, pix_y, active, line_start, frame_start, uo_out
  );

  modport slave (
    output rgb_in,
    input  pix_ce, pix_x, pix_y, active, line_start, frame_start, uo_out
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA pixel timing generator with registered Tiny VGA output byte.
// Divides the core clock by CLK_DIV into a one-cycle pixel strobe, runs the
// horizontal/vertical counters on that strobe and registers sync + blanked colour
// into uo_out, so the pins lag the counters by exactly one pixel period.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Reject geometries the 10-bit counters cannot represent.
  generate
    if (H_TOTAL > 1024) begin : g_h_total_check
      $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_total_check
      $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end
    if (CLK_DIV < 2) begin : g_div_check
      $error("vga_timing_gen: CLK_DIV must be at least 2");
    end
  endgenerate

  logic [DIV_W-1:0] div_reg;
  logic [9:0]       x_reg;
  logic [9:0]       y_reg;
  logic [7:0]       uo_reg;

  logic       pix_ce;
  logic       x_last;
  logic       y_last;
  logic       active;
  logic       hsync_n;
  logic       vsync_n;
  logic [5:0] colour;
  logic [7:0] uo_next;

  // Strobe, wrap detection, sync windows and the next pin byte, all from the current counters.
  always_comb begin
    pix_ce  = ena && (div_reg == DIV_LAST);
    x_last  = (x_reg == X_LAST);
    y_last  = (y_reg == Y_LAST);
    active  = (x_reg < X_VIS) && (y_reg < Y_VIS);
    hsync_n = !((x_reg >= HS_FIRST) && (x_reg <= HS_LAST));
    vsync_n = !((y_reg >= VS_FIRST) && (y_reg <= VS_LAST));
    colour  = active ? bus.rgb_in : 6'd0;
    // Tiny VGA PMOD order: {HS, B0, G0, R0, VS, B1, G1, R1}
    uo_next = {hsync_n, colour[0], colour[2], colour[4],
               vsync_n, colour[1], colour[3], colour[5]};
  end

  // Clock divider: free-runs 0..CLK_DIV-1 while enabled, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= '0;
    end else if (ena) begin
      div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
    end
  end

  // Horizontal and vertical counters, advanced once per pixel strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (pix_ce) begin
      if (x_last) begin
        x_reg <= '0;
        y_reg <= y_last ? 10'd0 : y_reg + 10'd1;
      end else begin
        x_reg <= x_reg + 10'd1;
      end
    end
  end

  // Pin register: captures the pre-increment pixel on each strobe; syncs idle high in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_reg <= 8'h88;
    end else if (pix_ce) begin
      uo_reg <= uo_next;
    end
  end

  assign bus.pix_ce      = pix_ce;
  assign bus.pix_x       = x_reg;
  assign bus.pix_y       = y_reg;
  assign bus.active      = active;
  assign bus.line_start  = pix_ce && x_last;
  assign bus.frame_start = pix_ce && x_last && y_last;
  assign bus.uo_out      = uo_reg;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel timing generator and Tiny VGA output stage. Runs on the 100 MHz core clock and divides it down to a ~25 MHz pixel rate. Produces the horizontal and vertical counters and the sync and blanking signals for 640x480@60. Sits directly upstream of the `uo_out` pins of `heichips25_template`: it samples a 6-bit colour from the pattern/PWM logic and drives the registered Tiny VGA PMOD byte.

## Interface
Parameters:
- `CLK_DIV`, 4: core clocks per pixel; must be ≥2.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.

Ports:
- `clk`  in  1  core clock, 100 MHz.
- `rst_n`  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `ena`  in  1  run enable; low freezes all state.
- `rgb_in`  in  6  colour for the current pixel, `{R1,R0,G1,G0,B1,B0}`.
- `pix_ce`  out  1  pixel strobe, one core cycle wide.
- `pix_x`  out  10  current horizontal count, 0..H_TOTAL-1.
- `pix_y`  out  10  current vertical count, 0..V_TOTAL-1.
- `active`  out  1  `(pix_x < H_ACTIVE) && (pix_y < V_ACTIVE)`.
- `line_start`  out  1  pulse when the horizontal count wraps.
- `frame_start`  out  1  pulse when both counts wrap.
- `uo_out`  out  8  Tiny VGA byte: [0]=R1, [1]=G1, [2]=B1, [3]=VSYNC, [4]=R0, [5]=G0, [6]=B0, [7]=HSYNC.

## Operation
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
  - Both totals must be ≤1024; otherwise elaboration fails with an error.
- Divider `div`:
  - Counts 0..CLK_DIV-1 while `ena`=1.
  - `pix_ce` = `ena && div==CLK_DIV-1`, so it is high once every CLK_DIV clocks.
- Counters, on a `pix_ce` cycle:
  - `pix_x` increments; it wraps H_TOTAL-1 → 0.
  - On that wrap, `pix_y` increments; it wraps V_TOTAL-1 → 0.
- Sync polarity is fixed active-low (640x480 standard).
  - hsync_n = 0 iff `pix_x` is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656, 751].
  - vsync_n = 0 iff `pix_y` is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490, 491].
- Output register: on each `pix_ce` cycle, `uo_out` loads from the current (pre-increment) counters and `rgb_in`.
  - Colour bits = `rgb_in` if `active`, else 0. Blanking overrides `rgb_in` unconditionally.
  - HSYNC and VSYNC bits are computed from the same counters.
  - Between strobes, `uo_out` holds.
- `line_start` = `pix_ce && pix_x==H_TOTAL-1`.
- `frame_start` = `pix_ce && pix_x==H_TOTAL-1 && pix_y==V_TOTAL-1`.
- `ena`=0:
  - `div`, counters and `uo_out` hold.
  - `pix_ce`, `line_start` and `frame_start` are forced 0.
  - Counting resumes with no skipped or repeated pixel.

## Timing
- Reset values (asynchronous, immediate on `rst_n` falling):
  - `div`=0, `pix_x`=0, `pix_y`=0.
  - `uo_out`=8'h88 (sync bits inactive-high, colour 0).
  - `pix_ce`=0, `line_start`=0, `frame_start`=0.
  - `active`=1, combinational from the counters.
- First `pix_ce` comes CLK_DIV clocks after reset release with `ena`=1; with CLK_DIV=4 that is the 4th rising edge.
- Latency:
  - `rgb_in` is sampled only on the `pix_ce` cycle. Upstream holds it stable, presented against `pix_x`/`pix_y`, for the whole pixel period.
  - `uo_out` reflects pixel (x,y) from the edge ending its `pix_ce` cycle, for exactly CLK_DIV clocks.
  - So the pins lag the counters by one pixel period. The syncs share that lag, so colour and syncs stay aligned.
- Pulse spacing with `ena` held high:
  - `line_start` pulses are 800×CLK_DIV = 3200 clocks apart.
  - `frame_start` pulses are 525×3200 = 1,680,000 clocks apart.
- Reset mid-frame: all state returns to reset values at once, and the next frame starts from (0,0) with no partial sync pulse.

## Test plan
- Reset and strobe: hold `rst_n`=0, then release with `ena`=1.
  - During reset, `uo_out`=8'h88 and `pix_x`=`pix_y`=0.
  - `pix_ce` fires on cycles 4, 8, 12, …; after the 3rd strobe, `pix_x`=3.
- Hsync window: run one line.
  - `uo_out[7]` goes 0 on the edge after the `pix_ce` with `pix_x`=656.
  - It returns to 1 after the strobe at `pix_x`=752; low width = 96×4 = 384 clocks.
  - `line_start` fires at `pix_x`=799.
- Vsync and frame: run two frames.
  - `uo_out[3]` is low for exactly 2 lines (6400 clocks), starting at `pix_y`=490.
  - `frame_start` pulses are 1,680,000 clocks apart.
- Blanking: hold `rgb_in`=6'h3F.
  - `uo_out` colour bits read 1 for x 0..639 in the output stream and 0 for x 640..799.
  - Colour bits are 0 for every line y ≥ 480.
- Enable freeze: drop `ena` at `pix_x`=100 for 37 clocks.
  - Counters, `div` and `uo_out` are unchanged and no strobes occur.
  - After re-raising `ena`, the next strobe advances to `pix_x`=101.
- Mid-frame reset: assert `rst_n`=0 at `pix_y`=300 for 1 clock.
  - `uo_out`=8'h88 and the counters read 0 immediately.
  - The next `frame_start` comes 1,680,000 clocks after release.
